load_issue_unit: RTL and testbench

- Drains the processor's load queue FIFO from its read side: pops one 22-bit load entry at a time, issues a memory read request, and returns the loaded word to register writeback with its destination tag.
- Sits between the load FIFO's read port (read enable, data out, empty) and the data-memory read port / writeback bus.
- Exactly one load in flight; loads complete in FIFO order.

---
 rtl/load_issue_unit.sv | 164 ++++++++++++++++
 tb/tb_load_issue_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_issue_unit.sv
// Load issue unit: pops load entries from the load FIFO, issues one memory read at a time
// and hands the returned word to register writeback with its destination tag.
module load_issue_unit #(
  parameter int unsigned WORD_SIZE = 22,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  // Load FIFO read side
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  input  logic [WORD_SIZE-1:0] fifo_data_i,
  // Data-memory read port
  output logic                 mem_req_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic                 mem_ack_i,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  // Register writeback
  output logic                 wb_valid_o,
  input  logic                 wb_ready_i,
  output logic [TAG_W-1:0]     wb_tag_o,
  output logic [DATA_W-1:0]    wb_data_o,
  // Status
  output logic                 busy_o,
  output logic                 timeout_err_o,
  output logic [15:0]          loads_done_o
);

  // Counter value after which one more un-acked cycle means the request has timed out.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StCapture,
    StReq,
    StWb
  } state_e;

  state_e              state_q, state_d;
  logic                fifo_rd_en_q, fifo_rd_en_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0]    wb_tag_q, wb_tag_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;
  logic [15:0]         loads_done_q, loads_done_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [7:0]          cnt_q, cnt_d;

  always_comb begin
    state_d       = state_q;
    fifo_rd_en_d  = 1'b0;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    wb_valid_d    = wb_valid_q;
    wb_tag_d      = wb_tag_q;
    wb_data_d     = wb_data_q;
    timeout_err_d = timeout_err_q;
    loads_done_d  = loads_done_q;
    tag_d         = tag_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty_i) begin
          state_d      = StPop;
          fifo_rd_en_d = 1'b1;
        end
      end

      StPop: begin
        state_d = StCapture;
      end

      // FIFO read data is valid here, one cycle after it sampled the read enable.
      StCapture: begin
        tag_d      = fifo_data_i[WORD_SIZE-1:ADDR_W];
        mem_addr_d = fifo_data_i[ADDR_W-1:0];
        mem_req_d  = 1'b1;
        cnt_d      = 8'd0;
        state_d    = StReq;
      end

      // An ack on the final allowed cycle still wins over the timeout.
      StReq: begin
        if (mem_ack_i) begin
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_tag_d   = tag_q;
          wb_data_d  = mem_rdata_i;
          state_d    = StWb;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TimeoutLast) begin
            mem_req_d     = 1'b0;
            timeout_err_d = 1'b1;
            state_d       = StIdle;
          end
        end
      end

      StWb: begin
        if (wb_ready_i) begin
          wb_valid_d   = 1'b0;
          loads_done_d = loads_done_q + 16'd1;
          state_d      = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fifo_rd_en_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_tag_q      <= '0;
      wb_data_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      loads_done_q  <= 16'd0;
      tag_q         <= '0;
      cnt_q         <= 8'd0;
    end else begin
      state_q       <= state_d;
      fifo_rd_en_q  <= fifo_rd_en_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      wb_valid_q    <= wb_valid_d;
      wb_tag_q      <= wb_tag_d;
      wb_data_q     <= wb_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      loads_done_q  <= loads_done_d;
      tag_q         <= tag_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fifo_rd_en_o  = fifo_rd_en_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_tag_o      = wb_tag_q;
  assign wb_data_o     = wb_data_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_err_q;
  assign loads_done_o  = loads_done_q;

endmodule

// File: tb/tb_load_issue_unit.sv
// Bench for load_issue_unit: a FIFO queue, a memory responder with per-load ack delay and a
// writeback sink, checked each cycle against a timeline model of every load transaction.
module tb_load_issue_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [21:0] fifo_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [5:0]  wb_tag;
  logic [31:0] wb_data;
  logic        busy;
  logic        timeout_err;
  logic [15:0] loads_done;

  always #5 clk = ~clk;

  load_issue_unit #(
    .WORD_SIZE(22),
    .TAG_W    (6),
    .ADDR_W   (16),
    .DATA_W   (32),
    .TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_data_i  (fifo_data),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata),
    .wb_valid_o   (wb_valid),
    .wb_ready_i   (wb_ready),
    .wb_tag_o     (wb_tag),
    .wb_data_o    (wb_data),
    .busy_o       (busy),
    .timeout_err_o(timeout_err),
    .loads_done_o (loads_done)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference state: one transaction timeline anchored at its pop cycle.
  logic [21:0] fifo_q[$];
  logic [21:0] cur;
  bit          active, exp_wbv, exp_terr, nxt_rd, prev_rd, prev_ready, cur_exp_req;
  int          t_pop, t_wb, ack_at;
  logic [31:0] ack_rdata;
  logic [15:0] exp_done;
  int          pops[$];

  // Stimulus knobs.
  int unsigned ack_lo = 1, ack_hi = 1, ready_pct = 100, spur_pct = 0;
  int          ready_wait = 0;
  bit          rdata_fix_en = 1'b0;
  logic [31:0] rdata_fix = 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    fifo_empty = (fifo_q.size() == 0);
    nxt_rd     = !active && !fifo_empty;
    if (active && !exp_wbv && ack_at <= TO && cyc == t_pop + 1 + ack_at) begin
      mem_ack   = 1'b1;
      mem_rdata = rdata_fix_en ? rdata_fix : $urandom;
      ack_rdata = mem_rdata;
    end else begin
      mem_ack   = !cur_exp_req && ($urandom_range(0, 99) < spur_pct);
      mem_rdata = $urandom;
    end
    if (exp_wbv) wb_ready = (cyc - t_wb >= ready_wait) && ($urandom_range(0, 99) < ready_pct);
    else         wb_ready = $urandom_range(0, 99) < spur_pct;
    prev_ready = wb_ready;
  endtask

  task automatic step();
    drive();
    @(posedge clk);
    #1;
    cyc++;
    // The FIFO presents the popped entry the cycle after it saw the read enable.
    if (prev_rd && fifo_q.size() > 0) begin
      cur       = fifo_q.pop_front();
      fifo_data = cur;
    end else begin
      fifo_data = 22'($urandom);
    end
    prev_rd = fifo_rd_en;

    check("fifo_rd_en", fifo_rd_en, nxt_rd);
    if (nxt_rd) begin
      active = 1'b1;
      t_pop  = cyc;
      pops.push_back(cyc);
      ack_at = int'($urandom_range(ack_hi, ack_lo));
    end
    if (active && ack_at > TO && cyc == t_pop + 2 + TO) begin
      active   = 1'b0;
      exp_terr = 1'b1;
    end
    if (active && ack_at <= TO && cyc == t_pop + 2 + ack_at) begin
      exp_wbv = 1'b1;
      t_wb    = cyc;
    end else if (exp_wbv && prev_ready) begin
      exp_wbv = 1'b0;
      active  = 1'b0;
      exp_done++;
    end
    cur_exp_req = active && !exp_wbv && (cyc >= t_pop + 2);

    check("mem_req", mem_req, cur_exp_req);
    if (cur_exp_req) check("mem_addr", mem_addr, cur[15:0]);
    check("wb_valid", wb_valid, exp_wbv);
    if (exp_wbv) begin
      check("wb_tag", wb_tag, cur[21:16]);
      check("wb_data", wb_data, ack_rdata);
    end
    check("busy", busy, active);
    check("timeout_err", timeout_err, exp_terr);
    check("loads_done", loads_done, exp_done);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    fifo_empty = (fifo_q.size() == 0);
    mem_ack    = 1'b1;
    mem_rdata  = $urandom;
    wb_ready   = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    check("rst_fifo_rd_en", fifo_rd_en, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_tag", wb_tag, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_loads_done", loads_done, 0);
    reset       = 1'b0;
    active      = 1'b0;
    exp_wbv     = 1'b0;
    exp_terr    = 1'b0;
    exp_done    = 16'd0;
    prev_rd     = 1'b0;
    cur_exp_req = 1'b0;
    fifo_data   = 22'($urandom);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((active || fifo_q.size() > 0) && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_done", active || (fifo_q.size() > 0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int seen;
    reset      = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    wb_ready   = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Empty FIFO: nothing may move.
    repeat (20) step();

    // Single load, ack one cycle after the request.
    ack_lo = 2; ack_hi = 2;
    rdata_fix_en = 1'b1; rdata_fix = 32'hDEADBEEF;
    fifo_q.push_back({6'h15, 16'h1234});
    drain(40);
    check("single_done", loads_done, 16'd1);
    rdata_fix_en = 1'b0;

    // Three queued loads, immediate ack and ready: pops every 5 cycles.
    ack_lo = 1; ack_hi = 1;
    pops.delete();
    repeat (3) fifo_q.push_back(22'($urandom));
    drain(60);
    check("burst_pops", pops.size(), 3);
    for (int i = 1; i < pops.size(); i++) check("pop_spacing", pops[i] - pops[i-1], 5);
    check("burst_done", loads_done, 16'd4);

    // Unanswered request times out, then the next entry completes normally.
    ack_lo = TO + 1; ack_hi = TO + 1;
    fifo_q.push_back(22'($urandom));
    step();
    ack_lo = 1; ack_hi = 3;
    fifo_q.push_back(22'($urandom));
    drain(80);
    check("terr_sticky", timeout_err, 1);
    check("timeout_done", loads_done, 16'd5);

    // Writeback stalled four cycles with more entries waiting.
    ready_wait = 4;
    repeat (2) fifo_q.push_back(22'($urandom));
    drain(80);
    ready_wait = 0;
    check("stall_done", loads_done, 16'd7);

    // Reset in the middle of a request; late acks afterwards are ignored.
    ack_lo = TO + 1; ack_hi = TO + 1;
    fifo_q.push_back(22'($urandom));
    seen = 0;
    for (int i = 0; i < 20 && seen < 3; i++) begin
      step();
      if (mem_req) seen++;
    end
    check("req_seen", seen, 3);
    do_reset();
    spur_pct = 100;
    repeat (6) step();

    // Randomised traffic: mixed ack delays (some timing out), random ready, stray acks.
    ack_lo = 1; ack_hi = TO + 2; ready_pct = 60; spur_pct = 20;
    for (int i = 0; i < 2500; i++) begin
      if (fifo_q.size() < 4 && $urandom_range(0, 99) < 30) fifo_q.push_back(22'($urandom));
      step();
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
